// File: rtl/kyber_pkg.sv
// Shared Kyber definitions used by ntt and poly_basemul: ring constants, coefficient type,
// FSM state type, base-multiplication gamma table and canonical modular add/sub helpers.
package kyber_pkg;

  localparam int N = 256;
  localparam int Q = 3329;
  localparam int W = 12;

  typedef logic [W-1:0] coeff_t;
  typedef logic [127:0][W-1:0] gamma_tab_t;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  // gamma_k = 17^(2*br7(k)+1) mod Q, evaluated at elaboration by square-and-multiply
  function automatic gamma_tab_t gen_gamma();
    gamma_tab_t t;
    int r, e, res, base;
    t = '0;
    for (int k = 0; k < 128; k++) begin
      r = 0;
      for (int bi = 0; bi < 7; bi++)
        if (((k >> bi) & 1) == 1) r = r | (1 << (6 - bi));
      e = 2 * r + 1;
      res = 1;
      base = 17;
      for (int bi = 0; bi < 8; bi++) begin
        if (((e >> bi) & 1) == 1) res = (res * base) % Q;
        base = (base * base) % Q;
      end
      t[k] = W'(res);
    end
    return t;
  endfunction

  localparam gamma_tab_t GAMMA = gen_gamma();

  function automatic coeff_t mod_add(input coeff_t x, input coeff_t y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= (W+1)'(Q)) ? W'(s - (W+1)'(Q)) : W'(s);
  endfunction

  function automatic coeff_t mod_sub(input coeff_t x, input coeff_t y);
    logic [W:0] s;
    s = {1'b0, x} + (W+1)'(Q) - {1'b0, y};
    return (s >= (W+1)'(Q)) ? W'(s - (W+1)'(Q)) : W'(s);
  endfunction

endpackage

// File: rtl/mod_mul_q.sv
// Combinational 12x12 modular multiply with Barrett reduction to [0, Q-1].
module mod_mul_q
  import kyber_pkg::*;
(
  input  coeff_t a,
  input  coeff_t b,
  output coeff_t r
);

  // floor(2^24 / Q); the quotient estimate is low by at most one, so one subtract suffices
  localparam logic [12:0] BARRETT_M = 13'd5039;

  logic [23:0] prod;
  logic [36:0] est;
  logic [12:0] qhat;
  logic [23:0] rem;

  assign prod = {12'b0, a} * {12'b0, b};
  assign est  = {13'b0, prod} * {24'b0, BARRETT_M};
  assign qhat = 13'(est >> 24);
  assign rem  = prod - ({11'b0, qhat} * 24'(Q));
  assign r    = (rem >= 24'(Q)) ? W'(rem - 24'(Q)) : W'(rem);

endmodule

// File: rtl/poly_basemul.sv
// NTT-domain pointwise multiplier: 128 degree-1 base products mod (X^2 - gamma_k), one pair per cycle.
// Optional accumulate mode (c += a*b) is enabled by defining BASEMUL_ACC_EN.
module poly_basemul
  import kyber_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   start_i,
  input  coeff_t a_i [N],
  input  coeff_t b_i [N],
  output coeff_t c_o [N],
  output logic   done_o
`ifdef BASEMUL_ACC_EN
  ,
  input  logic   acc_i
`endif
);

  state_t     state_reg;
  logic [6:0] k_reg;
  logic [1:0] drain_reg;
  logic       acc_reg;

  // issue stage latches the operand pair, then S1 products, S2 gamma product, S3 add/write
  logic       v0_reg, v1_reg, v2_reg;
  logic [6:0] k0_reg, k1_reg, k2_reg;
  coeff_t     opa_reg [2];
  coeff_t     opb_reg [2];
  coeff_t     prod    [4];
  coeff_t     p1_reg  [4];
  coeff_t     p11g;
  coeff_t     p2_reg  [4];
  coeff_t     sum_even, sum_odd, wr_even, wr_odd;

`ifdef BASEMUL_ACC_EN
  logic acc_sel;
  assign acc_sel = acc_i;
`else
  logic acc_sel;
  assign acc_sel = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg <= ST_IDLE;
      k_reg     <= '0;
      drain_reg <= '0;
      acc_reg   <= 1'b0;
      done_o    <= 1'b0;
      v0_reg    <= 1'b0;
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
    end else begin
      v0_reg <= 1'b0;
      v1_reg <= v0_reg;
      v2_reg <= v1_reg;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_reg <= ST_RUN;
            k_reg     <= '0;
            acc_reg   <= acc_sel;
            done_o    <= 1'b0;
          end
        end
        ST_RUN: begin
          v0_reg <= 1'b1;
          k_reg  <= k_reg + 7'd1;
          if (k_reg == 7'd127) begin
            state_reg <= ST_DRAIN;
            drain_reg <= '0;
          end
        end
        ST_DRAIN: begin
          drain_reg <= drain_reg + 2'd1;
          if (drain_reg == 2'd3) begin
            state_reg <= ST_DONE;
            done_o    <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    k0_reg     <= k_reg;
    opa_reg[0] <= a_i[{k_reg, 1'b0}];
    opa_reg[1] <= a_i[{k_reg, 1'b1}];
    opb_reg[0] <= b_i[{k_reg, 1'b0}];
    opb_reg[1] <= b_i[{k_reg, 1'b1}];
    k1_reg     <= k0_reg;
    p1_reg     <= prod;
    k2_reg     <= k1_reg;
    p2_reg[0]  <= p1_reg[0];
    p2_reg[1]  <= p11g;
    p2_reg[2]  <= p1_reg[2];
    p2_reg[3]  <= p1_reg[3];
  end

  // products: a0*b0, a1*b1, a0*b1, a1*b0
  for (genvar gi = 0; gi < 4; gi++) begin : g_s1_mul
    mod_mul_q u_mul (
      .a(opa_reg[gi & 1]),
      .b(opb_reg[(gi ^ (gi >> 1)) & 1]),
      .r(prod[gi])
    );
  end

  mod_mul_q u_gamma_mul (
    .a(p1_reg[1]),
    .b(GAMMA[k1_reg]),
    .r(p11g)
  );

  assign sum_even = mod_add(p2_reg[0], p2_reg[1]);
  assign sum_odd  = mod_add(p2_reg[2], p2_reg[3]);
  assign wr_even  = acc_reg ? mod_add(c_o[{k2_reg, 1'b0}], sum_even) : sum_even;
  assign wr_odd   = acc_reg ? mod_add(c_o[{k2_reg, 1'b1}], sum_odd)  : sum_odd;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int j = 0; j < N; j++) c_o[j] <= '0;
    end else if (v2_reg) begin
      c_o[{k2_reg, 1'b0}] <= wr_even;
      c_o[{k2_reg, 1'b1}] <= wr_odd;
    end
  end

endmodule

// File: tb/tb_poly_basemul.sv
// Directed bench for poly_basemul: reset, base products, latency/handshake, mid-run reset, accumulate.
module tb_poly_basemul;
  import kyber_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   start = 1'b0;
  coeff_t a [N];
  coeff_t b [N];
  coeff_t c [N];
  logic   done;
`ifdef BASEMUL_ACC_EN
  logic   acc = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int gam [128];
  int exp_c [N];

  always #5 clk = ~clk;

  poly_basemul dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .start_i(start),
    .a_i    (a),
    .b_i    (b),
    .c_o    (c),
    .done_o (done)
`ifdef BASEMUL_ACC_EN
    ,
    .acc_i  (acc)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic compare_all(input string tag);
    for (int j = 0; j < N; j++) chk($sformatf("%s_c%0d", tag, j), c[j], exp_c[j]);
  endtask

  // golden model; gamma table built from an iterated power list
  task automatic model(input bit acc_mode);
    int a0, a1, b0, b1, ev, od;
    for (int k = 0; k < 128; k++) begin
      a0 = a[2*k]; a1 = a[2*k+1]; b0 = b[2*k]; b1 = b[2*k+1];
      ev = (a0 * b0 + ((a1 * b1) % Q) * gam[k]) % Q;
      od = (a0 * b1 + a1 * b0) % Q;
      if (acc_mode) begin
        exp_c[2*k]   = (exp_c[2*k] + ev) % Q;
        exp_c[2*k+1] = (exp_c[2*k+1] + od) % Q;
      end else begin
        exp_c[2*k]   = ev;
        exp_c[2*k+1] = od;
      end
    end
  endtask

  task automatic run(input string tag, input int glitch);
    int   cyc;
    logic was_done;
    was_done = done;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (was_done) chk({tag, "_restart_done_low"}, done, 0);
    cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin
      start = (cyc == glitch - 1);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, cyc, 132);
    $display("run %s: done after %0d cycles, c0=%0d c1=%0d c2=%0d c3=%0d", tag, cyc, c[0], c[1], c[2], c[3]);
  endtask

  initial begin
    int pw [256];
    int r;
    pw[0] = 1;
    for (int i = 1; i < 256; i++) pw[i] = (pw[i-1] * 17) % Q;
    for (int k = 0; k < 128; k++) begin
      r = 0;
      for (int bi = 0; bi < 7; bi++) if (((k >> bi) & 1) == 1) r = r | (1 << (6 - bi));
      gam[k] = pw[2*r+1];
    end
    for (int j = 0; j < N; j++) begin a[j] = '0; b[j] = '0; exp_c[j] = 0; end

    // reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", done, 0);
    compare_all("reset");
    $display("reset: done=%0d c0=%0d", done, c[0]);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // a[0]=1, b[j]=j
    for (int j = 0; j < N; j++) begin a[j] = '0; b[j] = coeff_t'(j % Q); end
    a[0] = 12'd1;
    model(1'b0);
    run("t1", -1);
    chk("t1_c0", c[0], 0);
    chk("t1_c1", c[1], 1);
    compare_all("t1");

    // gamma probe, with an ignored start pulse at RUN cycle 40
    for (int j = 0; j < N; j++) begin a[j] = '0; b[j] = '0; end
    a[1] = 12'd1; b[1] = 12'd1; a[3] = 12'd1; b[3] = 12'd1;
    model(1'b0);
    run("t2", 40);
    chk("t2_c0", c[0], 17);
    chk("t2_c2", c[2], 3312);
    compare_all("t2");

    // all Q-1 operands
    for (int j = 0; j < N; j++) begin a[j] = 12'd3328; b[j] = 12'd3328; end
    model(1'b0);
    run("t3", -1);
    chk("t3_c0", c[0], 18);
    chk("t3_c1", c[1], 2);
    chk("t3_c2", c[2], 3313);
    chk("t3_c3", c[3], 2);
    compare_all("t3");

    // reset at RUN cycle 50
    for (int j = 0; j < N; j++) begin a[j] = coeff_t'($urandom_range(Q-1, 0)); b[j] = coeff_t'($urandom_range(Q-1, 0)); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int j = 0; j < N; j++) exp_c[j] = 0;
    chk("midrst_done", done, 0);
    compare_all("midrst");
    $display("midrst: done=%0d c0=%0d", done, c[0]);

    // fresh random run
    for (int j = 0; j < N; j++) begin a[j] = coeff_t'($urandom_range(Q-1, 0)); b[j] = coeff_t'($urandom_range(Q-1, 0)); end
    model(1'b0);
    run("rand", -1);
    compare_all("rand");

`ifdef BASEMUL_ACC_EN
    for (int j = 0; j < N; j++) begin a[j] = 12'd3328; b[j] = 12'd3328; end
    acc = 1'b0;
    model(1'b0);
    run("acc0", -1);
    compare_all("acc0");
    acc = 1'b1;
    model(1'b1);
    run("acc1", -1);
    acc = 1'b0;
    chk("acc1_c0", c[0], 36);
    chk("acc1_c1", c[1], 4);
    chk("acc1_c2", c[2], 3297);
    chk("acc1_c3", c[3], 4);
    compare_all("acc1");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
